// File: rtl/add_header_mc.sv
// Multi-channel packet header inserter: per-channel data/length FIFOs, packet-level
// round-robin arbitration, headered output stream, capture-gated timestamp and hard-stop flush.
module add_header_mc #(
   parameter int         DW          = 512,
   parameter int         NUM_CH      = 2,
   parameter int         FIFO_DEPTH  = 256,
   parameter int         CH_BASE     = 0,
   parameter int         FLUSH_BEATS = 64,
   parameter logic [7:0] FILL_BYTE   = 8'hFC
) (
   input  logic                     clk,
   input  logic                     sys_reset,
   input  logic                     capture,
   input  logic [NUM_CH*DW-1:0]     AXIS_IN_TDATA,
   input  logic [NUM_CH*DW/8-1:0]   AXIS_IN_TKEEP,
   input  logic [NUM_CH-1:0]        AXIS_IN_TLAST,
   input  logic [NUM_CH-1:0]        AXIS_IN_TVALID,
   output logic [NUM_CH-1:0]        AXIS_IN_TREADY,
   output logic [DW-1:0]            AXIS_OUT_TDATA,
   output logic                     AXIS_OUT_TLAST,
   output logic                     AXIS_OUT_TVALID,
   input  logic                     AXIS_OUT_TREADY,
   output logic [NUM_CH-1:0]        len_overflow,
   output logic                     halted
);

   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int KW  = DW / 8;
   localparam int FCW = $clog2(FLUSH_BEATS + 1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_FLUSH, S_HALT} state_t;

   state_t            state;
   logic              rst_done;
   logic [CHW-1:0]    ptr, grant, gnt_next, gsel;
   logic              gnt_found;
   int unsigned       gi;
   logic              got_last;
   logic [FCW-1:0]    flush_cnt;
   logic [63:0]       ts;
   logic              ts_run, cap_d, hard_stop;
   logic [31:0]       seq [NUM_CH];
   logic [DW-1:0]     hdr;
   logic              out_fire, d_load;

   logic [DW:0]       d_head [NUM_CH];
   logic [15:0]       l_head [NUM_CH];
   logic [NUM_CH-1:0] d_nempty, l_nempty, d_pop, l_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DW:0]   dmem [FIFO_DEPTH];
      logic [15:0]   lmem [FIFO_DEPTH];
      logic [AW-1:0] d_wr, d_rd, l_wr, l_rd;
      logic [CW-1:0] d_cnt, l_cnt;
      logic [15:0]   acc;
      logic          ovf, in_fire, len_push;
      logic [16:0]   sum;
      logic [15:0]   sat;

      // Running byte count saturates; the TLAST beat contributes only its kept bytes.
      always_comb begin
         sum = {1'b0, acc} + (AXIS_IN_TLAST[g] ? 17'($countones(AXIS_IN_TKEEP[g*KW +: KW]))
                                               : 17'(KW));
         sat = sum[16] ? 16'hFFFF : sum[15:0];
      end

      assign AXIS_IN_TREADY[g] = rst_done && (d_cnt != CW'(FIFO_DEPTH)) && (l_cnt != CW'(FIFO_DEPTH));
      assign in_fire           = AXIS_IN_TVALID[g] & AXIS_IN_TREADY[g];
      assign len_push          = in_fire & AXIS_IN_TLAST[g];
      assign d_head[g]         = dmem[d_rd];
      assign l_head[g]         = lmem[l_rd];
      assign d_nempty[g]       = (d_cnt != '0);
      assign l_nempty[g]       = (l_cnt != '0);
      assign len_overflow[g]   = ovf;

      always_ff @(posedge clk) begin
         if (in_fire)  dmem[d_wr] <= {AXIS_IN_TLAST[g], AXIS_IN_TDATA[g*DW +: DW]};
         if (len_push) lmem[l_wr] <= sat;
      end

      always_ff @(posedge clk) begin
         if (sys_reset) begin
            d_wr  <= '0;
            d_rd  <= '0;
            l_wr  <= '0;
            l_rd  <= '0;
            d_cnt <= '0;
            l_cnt <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
         end else begin
            if (in_fire)  d_wr <= ptr_inc(d_wr);
            if (d_pop[g]) d_rd <= ptr_inc(d_rd);
            if (len_push) l_wr <= ptr_inc(l_wr);
            if (l_pop[g]) l_rd <= ptr_inc(l_rd);
            d_cnt <= d_cnt + CW'(in_fire) - CW'(d_pop[g]);
            l_cnt <= l_cnt + CW'(len_push) - CW'(l_pop[g]);
            if (in_fire) begin
               acc <= AXIS_IN_TLAST[g] ? '0 : sat;
               if (sum[16]) ovf <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      gnt_found = 1'b0;
      gnt_next  = '0;
      gi        = 0;
      gsel      = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         gi   = (32'(ptr) + k) % NUM_CH;
         gsel = CHW'(gi);
         if (!gnt_found && l_nempty[gsel]) begin
            gnt_found = 1'b1;
            gnt_next  = gsel;
         end
      end
   end

   always_comb begin
      hdr            = '0;
      hdr[55:0]      = 56'h666c6f57202e44;
      hdr[63:56]     = 8'(CH_BASE + 32'(gnt_next));
      hdr[127:64]    = ts;
      hdr[143:128]   = l_head[gnt_next];
      hdr[175:144]   = seq[gnt_next];
   end

   // Output register refills from the data FIFO whenever it is empty or being drained.
   always_comb begin
      out_fire = AXIS_OUT_TVALID & AXIS_OUT_TREADY;
      d_load   = (state == S_DATA) && !(out_fire && AXIS_OUT_TLAST) &&
                 (!AXIS_OUT_TVALID || AXIS_OUT_TREADY) && !got_last && d_nempty[grant];
      d_pop    = '0;
      l_pop    = '0;
      if (d_load)                       d_pop[grant] = 1'b1;
      if ((state == S_HDR) && out_fire) l_pop[grant] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (sys_reset) begin
         state           <= S_IDLE;
         rst_done        <= 1'b0;
         ptr             <= '0;
         grant           <= '0;
         got_last        <= 1'b0;
         flush_cnt       <= '0;
         ts              <= '0;
         ts_run          <= 1'b0;
         cap_d           <= 1'b0;
         hard_stop       <= 1'b0;
         halted          <= 1'b0;
         AXIS_OUT_TDATA  <= '0;
         AXIS_OUT_TLAST  <= 1'b0;
         AXIS_OUT_TVALID <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) seq[i] <= '0;
      end else begin
         rst_done <= 1'b1;
         cap_d    <= capture;
         if (cap_d && !capture) hard_stop <= 1'b1;
         if (capture)           ts_run    <= 1'b1;
         if (ts_run)            ts        <= ts + 64'd1;
         case (state)
            S_IDLE: begin
               if (hard_stop) begin
                  AXIS_OUT_TDATA  <= {KW{FILL_BYTE}};
                  AXIS_OUT_TLAST  <= 1'b0;
                  AXIS_OUT_TVALID <= 1'b1;
                  flush_cnt       <= '0;
                  state           <= S_FLUSH;
               end else if (gnt_found) begin
                  grant           <= gnt_next;
                  AXIS_OUT_TDATA  <= hdr;
                  AXIS_OUT_TLAST  <= 1'b0;
                  AXIS_OUT_TVALID <= 1'b1;
                  state           <= S_HDR;
               end
            end
            S_HDR: begin
               if (AXIS_OUT_TREADY) begin
                  seq[grant]      <= seq[grant] + 32'd1;
                  ptr             <= (grant == CHW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                  AXIS_OUT_TVALID <= 1'b0;
                  got_last        <= 1'b0;
                  state           <= S_DATA;
               end
            end
            S_DATA: begin
               if (out_fire && AXIS_OUT_TLAST) begin
                  AXIS_OUT_TVALID <= 1'b0;
                  AXIS_OUT_TLAST  <= 1'b0;
                  state           <= S_IDLE;
               end else if (!AXIS_OUT_TVALID || AXIS_OUT_TREADY) begin
                  if (d_load) begin
                     AXIS_OUT_TDATA  <= d_head[grant][DW-1:0];
                     AXIS_OUT_TLAST  <= d_head[grant][DW];
                     AXIS_OUT_TVALID <= 1'b1;
                     got_last        <= d_head[grant][DW];
                  end else begin
                     AXIS_OUT_TVALID <= 1'b0;
                  end
               end
            end
            S_FLUSH: begin
               if (AXIS_OUT_TREADY) begin
                  flush_cnt <= flush_cnt + 1'b1;
                  if (flush_cnt == FCW'(FLUSH_BEATS - 1)) begin
                     AXIS_OUT_TVALID <= 1'b0;
                     halted          <= 1'b1;
                     state           <= S_HALT;
                  end
               end
            end
            S_HALT:  AXIS_OUT_TVALID <= 1'b0;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_header_mc.sv
// Scoreboard bench for add_header_mc: 4 channels, DW=512; expected headers/beats are
// queued per channel as stimulus is driven and popped as the output stream is observed.
module tb_add_header_mc;

   localparam int DW  = 512;
   localparam int NCH = 4;
   localparam int KW  = DW / 8;

   logic                 clk = 1'b0;
   logic                 sys_reset;
   logic                 capture;
   logic [NCH*DW-1:0]    AXIS_IN_TDATA;
   logic [NCH*KW-1:0]    AXIS_IN_TKEEP;
   logic [NCH-1:0]       AXIS_IN_TLAST;
   logic [NCH-1:0]       AXIS_IN_TVALID;
   logic [NCH-1:0]       AXIS_IN_TREADY;
   logic [DW-1:0]        AXIS_OUT_TDATA;
   logic                 AXIS_OUT_TLAST;
   logic                 AXIS_OUT_TVALID;
   logic                 AXIS_OUT_TREADY;
   logic [NCH-1:0]       len_overflow;
   logic                 halted;

   always #5 clk = ~clk;

   add_header_mc #(
      .DW(DW), .NUM_CH(NCH), .FIFO_DEPTH(1100), .CH_BASE(0),
      .FLUSH_BEATS(64), .FILL_BYTE(8'hFC)
   ) dut (
      .clk(clk), .sys_reset(sys_reset), .capture(capture),
      .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TKEEP(AXIS_IN_TKEEP),
      .AXIS_IN_TLAST(AXIS_IN_TLAST), .AXIS_IN_TVALID(AXIS_IN_TVALID),
      .AXIS_IN_TREADY(AXIS_IN_TREADY),
      .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TLAST(AXIS_OUT_TLAST),
      .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
      .len_overflow(len_overflow), .halted(halted)
   );

   typedef struct packed {
      logic [15:0] len;
      logic [31:0] seq;
   } hdr_t;

   hdr_t         exp_hdr [NCH][$];
   logic [DW:0]  exp_dat [NCH][$];
   int unsigned  seq_m [NCH];
   int           hdr_log [$];

   int           n_chk = 0;
   int           n_pass = 0;
   int           rdy_mode = 1;
   bit           flush_mode = 0;
   int           fill_cnt = 0;
   bit           in_pkt = 0;
   int           cur_ch = 0;
   logic [63:0]  last_ts = '0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic wait_in_rdy(input int ch);
      int n = 0;
      forever begin
         @(negedge clk);
         if (AXIS_IN_TREADY[ch]) break;
         n++;
         if (n > 20000) begin
            $display("FAIL in_ready_timeout: channel %0d never ready", ch);
            $fatal(1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int ch, input int nb, input logic [KW-1:0] lastkeep);
      int          len;
      hdr_t        h;
      logic [DW-1:0] d;
      logic        last;
      len   = (nb - 1) * KW + $countones(lastkeep);
      h.len = (len > 65535) ? 16'hFFFF : 16'(len);
      h.seq = seq_m[ch];
      seq_m[ch]++;
      exp_hdr[ch].push_back(h);
      for (int b = 0; b < nb; b++) begin
         d    = rnd_word();
         last = (b == nb - 1);
         exp_dat[ch].push_back({last, d});
         AXIS_IN_TDATA[ch*DW +: DW] = d;
         AXIS_IN_TKEEP[ch*KW +: KW] = last ? lastkeep : '1;
         AXIS_IN_TLAST[ch]          = last;
         AXIS_IN_TVALID[ch]         = 1'b1;
         wait_in_rdy(ch);
      end
      AXIS_IN_TVALID[ch] = 1'b0;
      AXIS_IN_TLAST[ch]  = 1'b0;
   endtask

   function automatic bit sb_empty();
      for (int c = 0; c < NCH; c++)
         if (exp_hdr[c].size() != 0 || exp_dat[c].size() != 0) return 0;
      return !in_pkt;
   endfunction

   task automatic wait_drain(input int budget);
      int n = 0;
      while (!sb_empty() && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain", n < budget, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pkt();
      int n = 0;
      while (!in_pkt && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("pkt_start", n < 5000, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 sys_reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_tvalid", AXIS_OUT_TVALID, 0);
      check("rst_tdata", AXIS_OUT_TDATA, 0);
      check("rst_tlast", AXIS_OUT_TLAST, 0);
      check("rst_halted", halted, 0);
      check("rst_ovf", len_overflow, 0);
      check("rst_in_ready", AXIS_IN_TREADY, 0);
      for (int c = 0; c < NCH; c++) begin
         exp_hdr[c].delete();
         exp_dat[c].delete();
         seq_m[c] = 0;
      end
      flush_mode = 0;
      fill_cnt   = 0;
      @(posedge clk);
      #1 sys_reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      AXIS_OUT_TREADY = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       AXIS_OUT_TREADY = 1'b0;
            1:       AXIS_OUT_TREADY = 1'b1;
            default: AXIS_OUT_TREADY = ($urandom_range(0, 99) < 30);
         endcase
      end
   end

   // Output monitor: stall stability, header fields, data beats and filler.
   logic          pv = 0, pr = 0, pl = 0;
   logic [DW-1:0] pd = '0;
   always @(negedge clk) begin
      int   ch;
      hdr_t h;
      logic [DW:0] e;
      if (sys_reset) begin
         in_pkt  = 0;
         last_ts = '0;
         pv      = 0;
      end else begin
         if (pv && !pr) begin
            check("stall_valid", AXIS_OUT_TVALID, 1);
            check("stall_data", AXIS_OUT_TDATA, pd);
            check("stall_last", AXIS_OUT_TLAST, pl);
         end
         if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
            if (in_pkt) begin
               check("data_avail", exp_dat[cur_ch].size() != 0, 1);
               if (exp_dat[cur_ch].size() != 0) begin
                  e = exp_dat[cur_ch].pop_front();
                  check("data", AXIS_OUT_TDATA, e[DW-1:0]);
                  check("data_last", AXIS_OUT_TLAST, e[DW]);
                  if (e[DW]) in_pkt = 0;
               end
            end else if (flush_mode) begin
               check("fill_data", AXIS_OUT_TDATA, {KW{8'hFC}});
               check("fill_last", AXIS_OUT_TLAST, 0);
               fill_cnt++;
            end else begin
               ch = int'(AXIS_OUT_TDATA[63:56]);
               check("hdr_magic", AXIS_OUT_TDATA[55:0], 56'h666c6f57202e44);
               check("hdr_ch_range", ch < NCH, 1);
               if (ch < NCH) begin
                  check("hdr_avail", exp_hdr[ch].size() != 0, 1);
                  if (exp_hdr[ch].size() != 0) begin
                     h = exp_hdr[ch].pop_front();
                     check("hdr_len", AXIS_OUT_TDATA[143:128], h.len);
                     check("hdr_seq", AXIS_OUT_TDATA[175:144], h.seq);
                  end
               end
               check("hdr_pad", AXIS_OUT_TDATA[DW-1:176], 0);
               check("hdr_ts_inc", AXIS_OUT_TDATA[127:64] > last_ts, 1);
               check("hdr_last", AXIS_OUT_TLAST, 0);
               last_ts = AXIS_OUT_TDATA[127:64];
               hdr_log.push_back(ch);
               cur_ch = (ch < NCH) ? ch : 0;
               in_pkt = 1;
            end
         end
         pv = AXIS_OUT_TVALID;
         pr = AXIS_OUT_TREADY;
         pd = AXIS_OUT_TDATA;
         pl = AXIS_OUT_TLAST;
      end
   end

   initial begin
      int n;
      sys_reset      = 1'b1;
      capture        = 1'b0;
      AXIS_IN_TDATA  = '0;
      AXIS_IN_TKEEP  = '0;
      AXIS_IN_TLAST  = '0;
      AXIS_IN_TVALID = '0;
      for (int c = 0; c < NCH; c++) seq_m[c] = 0;
      do_reset();
      capture = 1'b1;

      // single 3-beat packet, 16 bytes kept on the last beat -> len 144
      rdy_mode = 1;
      hdr_log.delete();
      send_pkt(0, 3, 64'h0000_0000_0000_FFFF);
      wait_drain(2000);
      check("single_hdr_count", hdr_log.size(), 1);

      // round robin over preloaded channels
      do_reset();
      rdy_mode = 0;
      hdr_log.delete();
      for (int p = 0; p < 2; p++)
         for (int c = 0; c < NCH; c++) send_pkt(c, 1 + c, '1);
      rdy_mode = 1;
      wait_drain(2000);
      check("rr_count", hdr_log.size(), 8);
      for (int k = 0; k < 8; k++)
         if (k < hdr_log.size()) check("rr_order", hdr_log[k], k % NCH);

      // random traffic under 30% output ready
      rdy_mode = 2;
      for (int p = 0; p < 1000; p++)
         send_pkt($urandom_range(0, NCH - 1), $urandom_range(1, 4), {$urandom, $urandom});
      wait_drain(60000);

      // length saturation
      rdy_mode = 1;
      send_pkt(2, 1025, '1);
      wait_drain(5000);
      check("ovf_flag", len_overflow, 4'b0100);

      // reset in the middle of a packet; seq restarts at 0
      rdy_mode = 2;
      send_pkt(1, 8, '1);
      wait_pkt();
      do_reset();
      rdy_mode = 1;
      send_pkt(1, 2, '1);
      wait_drain(2000);

      // hard stop during a 10-beat packet
      send_pkt(3, 10, '1);
      wait_pkt();
      flush_mode = 1;
      capture    = 1'b0;
      n = 0;
      while (fill_cnt < 64 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      check("flush_count", fill_cnt, 64);
      check("flush_pkt_done", exp_dat[3].size(), 0);
      check("flush_in_pkt", in_pkt, 0);
      check("halt_tvalid", AXIS_OUT_TVALID, 0);
      check("halt_flag", halted, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
